// File: rtl/adc_lvds_pattern_tx_pkg.sv
// Shared types and constants for the AD9284-style LVDS pattern transmitter.
package adc_lvds_pattern_tx_pkg;

   localparam int unsigned SAMPLE_W = 8;
   localparam int unsigned PAIR_W   = 16;
   localparam int unsigned CODE_W   = 3;
   localparam int unsigned CNT_W    = 16;
   localparam int unsigned PN_W     = 9;

   typedef enum logic [CODE_W-1:0] {
      PAT_MIDSCALE = 3'd0,
      PAT_FIXED    = 3'd1,
      PAT_CHECKER  = 3'd2,
      PAT_RAMP     = 3'd3,
      PAT_PN9      = 3'd4,
      PAT_TOGGLE   = 3'd5,
      PAT_STREAM   = 3'd6,
      PAT_RESERVED = 3'd7
   } pattern_e;

   localparam logic [SAMPLE_W-1:0] ADC_MIDSCALE = 8'h80;
   // x^9 + x^5 + 1: feedback from state bits 8 and 4
   localparam logic [PN_W-1:0]     PN9_TAPS     = 9'h110;

   typedef struct packed {
      logic [SAMPLE_W-1:0] b;
      logic [SAMPLE_W-1:0] a;
   } sample_pair_t;

   localparam sample_pair_t MIDSCALE_PAIR = '{b: ADC_MIDSCALE, a: ADC_MIDSCALE};

endpackage

// File: rtl/adc_lvds_pattern_tx_if.sv
// Stream sample-pair handshake into the pattern transmitter.
interface adc_lvds_pattern_tx_if;
   import adc_lvds_pattern_tx_pkg::*;

   sample_pair_t s_data;
   logic         s_valid;
   logic         s_ready;

   modport master (output s_data, output s_valid, input  s_ready);
   modport slave  (input  s_data, input  s_valid, output s_ready);

endinterface

// File: rtl/adc_lvds_pattern_tx_pn9_gen.sv
// PN9 LFSR advancing 16 bits per clock; word_c[15] is the first bit shifted out.
module adc_lvds_pattern_tx_pn9_gen
   import adc_lvds_pattern_tx_pkg::*;
#(
   parameter logic [PN_W-1:0] SEED = 9'h1FF
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              load,
   input  logic              advance,
   output logic [PAIR_W-1:0] word_c
);

   logic [PN_W-1:0] state;
   logic [PN_W-1:0] state_next;
   logic [PN_W-1:0] walk;

   // Unrolled 16-step Fibonacci shift; output bit is the MSB before each shift
   always_comb begin
      walk   = state;
      word_c = '0;
      for (int i = 0; i < int'(PAIR_W); i++) begin
         word_c[PAIR_W-1-i] = walk[PN_W-1];
         walk = {walk[PN_W-2:0], ^(walk & PN9_TAPS)};
      end
      state_next = walk;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)     state <= SEED;
      else if (load)    state <= SEED;
      else if (advance) state <= state_next;
   end

endmodule

// File: rtl/adc_lvds_pattern_tx.sv
// ADC LVDS output emulator: pattern/stream generator, monitor registers and DDR launch.
module adc_lvds_pattern_tx
   import adc_lvds_pattern_tx_pkg::*;
#(
   parameter int unsigned     STABLE_CYCLES = 16,
   parameter logic [PN_W-1:0] PN_SEED       = 9'h1FF,
   parameter bit              SIM_DDR       = 1'b0
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                enable,
   input  logic [CODE_W-1:0]   pattern_sel,
   input  logic [PAIR_W-1:0]   user_word,
   adc_lvds_pattern_tx_if.slave s_bus,
   output logic [SAMPLE_W-1:0] data_a,
   output logic [SAMPLE_W-1:0] data_b,
   output logic [CODE_W-1:0]   pattern_active,
   output logic                pattern_changed,
   output logic [CNT_W-1:0]    underrun_count,
   output logic                dco_p,
   output logic                dco_n,
   output logic [SAMPLE_W-1:0] data_p,
   output logic [SAMPLE_W-1:0] data_n
);

   localparam int unsigned STAB_W = $clog2(STABLE_CYCLES + 1);

   logic [CODE_W-1:0]   sel_meta, sel_sync, sel_prev;
   logic [STAB_W-1:0]   stable_cnt;
   pattern_e            active_q;
   logic                apply_c;
   pattern_e            next_active_c;
   logic [SAMPLE_W-1:0] ramp;
   logic                phase;
   sample_pair_t        hold;
   sample_pair_t        gen_c;
   logic                accept_c;
   logic                pn_adv_c;
   logic [PAIR_W-1:0]   pn_word_c;

   assign pattern_active = active_q;

   // Apply only after the synchronised code has been steady long enough
   assign apply_c       = (stable_cnt == STAB_W'(STABLE_CYCLES)) && (sel_sync == sel_prev)
                          && (sel_sync != active_q);
   assign next_active_c = apply_c ? pattern_e'(sel_sync) : active_q;
   assign accept_c      = s_bus.s_valid && s_bus.s_ready;
   assign pn_adv_c      = enable && (active_q == PAT_PN9) && !apply_c;

   adc_lvds_pattern_tx_pn9_gen #(.SEED(PN_SEED)) u_pn9 (
      .clock   (clock),
      .reset_n (reset_n),
      .load    (apply_c),
      .advance (pn_adv_c),
      .word_c  (pn_word_c)
   );

   always_comb begin
      gen_c = MIDSCALE_PAIR;
      case (active_q)
         PAT_FIXED:   gen_c = sample_pair_t'(user_word);
         PAT_CHECKER: gen_c = phase ? '{b: 8'hAA, a: 8'h55} : '{b: 8'h55, a: 8'hAA};
         PAT_RAMP:    gen_c = '{b: ~ramp, a: ramp};
         PAT_PN9:     gen_c = '{b: pn_word_c[7:0], a: pn_word_c[15:8]};
         PAT_TOGGLE:  gen_c = phase ? '{b: 8'h00, a: 8'h00} : '{b: 8'hFF, a: 8'hFF};
         PAT_STREAM:  gen_c = accept_c ? s_bus.s_data : hold;
         default:     gen_c = MIDSCALE_PAIR;
      endcase
      if (!enable) gen_c = MIDSCALE_PAIR;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sel_meta        <= '0;
         sel_sync        <= '0;
         sel_prev        <= '0;
         stable_cnt      <= '0;
         active_q        <= PAT_MIDSCALE;
         pattern_changed <= 1'b0;
         data_a          <= ADC_MIDSCALE;
         data_b          <= ADC_MIDSCALE;
         ramp            <= '0;
         phase           <= 1'b0;
         hold            <= MIDSCALE_PAIR;
         s_bus.s_ready   <= 1'b0;
         underrun_count  <= '0;
      end else begin
         sel_meta        <= pattern_sel;
         sel_sync        <= sel_meta;
         sel_prev        <= sel_sync;
         if (sel_sync != sel_prev)                      stable_cnt <= '0;
         else if (stable_cnt != STAB_W'(STABLE_CYCLES)) stable_cnt <= stable_cnt + STAB_W'(1);
         active_q        <= next_active_c;
         pattern_changed <= apply_c;
         data_a          <= gen_c.a;
         data_b          <= gen_c.b;
         if (apply_c) begin
            ramp  <= '0;
            phase <= 1'b0;
         end else if (enable) begin
            if (active_q == PAT_RAMP) ramp <= ramp + SAMPLE_W'(1);
            if ((active_q == PAT_CHECKER) || (active_q == PAT_TOGGLE)) phase <= ~phase;
         end
         if (accept_c) hold <= s_bus.s_data;
         s_bus.s_ready   <= enable && (next_active_c == PAT_STREAM);
         if (s_bus.s_ready && !s_bus.s_valid && enable && (active_q == PAT_STREAM)
             && (underrun_count != {CNT_W{1'b1}}))
            underrun_count <= underrun_count + CNT_W'(1);
      end
   end

   // DDR launch: A in the clock-high half, B in the low half, one clock after data_a/b
   if (SIM_DDR) begin : g_ddr_sim
      logic [SAMPLE_W-1:0] q_a, q_b;
      logic                dco_q;

      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            q_a   <= '0;
            q_b   <= '0;
            dco_q <= 1'b0;
         end else begin
            q_a   <= data_a;
            q_b   <= data_b;
            dco_q <= 1'b1;
         end
      end

      assign data_p = clock ? q_a : q_b;
      assign dco_p  = clock & dco_q;
   end else begin : g_ddr_flop
      // Dual-edge flops XOR-combined so no clock enters the data path
      logic [SAMPLE_W-1:0] rise_d, fall_d, hold_b;
      logic                rise_c, fall_c;

      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            rise_d <= '0;
            hold_b <= '0;
            rise_c <= 1'b0;
         end else begin
            rise_d <= data_a ^ fall_d;
            hold_b <= data_b;
            rise_c <= ~fall_c;
         end
      end

      always_ff @(negedge clock or negedge reset_n) begin
         if (!reset_n) begin
            fall_d <= '0;
            fall_c <= 1'b0;
         end else begin
            fall_d <= hold_b ^ rise_d;
            fall_c <= rise_c;
         end
      end

      assign data_p = rise_d ^ fall_d;
      assign dco_p  = rise_c ^ fall_c;
   end

   assign data_n = ~data_p;
   assign dco_n  = ~dco_p;

endmodule
